// File: rtl/phase_sequencer.sv
// Sequencer for the three-phase C1/C2/C3 clock generator: run/step/halt control,
// C2 memory wait states with timeout, and a completed-instruction-cycle counter.
module phase_sequencer #(
    parameter int WAIT_MAX = 7,
    parameter int CNT_W    = 16
) (
    input  logic             Cin,
    input  logic             Reset,
    input  logic             Run,
    input  logic             Step,
    input  logic             Halt_req,
    input  logic             Clear,
    input  logic             Mem_req,
    input  logic             Mem_ready,
    output logic             Advance,
    output logic [1:0]       Phase,
    output logic [2:0]       State,
    output logic             Cycle_done,
    output logic             Timeout,
    output logic [CNT_W-1:0] Cycle_count
);

    localparam int WC_W = $clog2(WAIT_MAX + 1);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        RUN    = 3'd1,
        STEP   = 3'd2,
        WAIT   = 3'd3,
        HALTED = 3'd4
    } state_t;

    state_t            state, state_n;
    logic [1:0]        phase_n;
    logic [WC_W-1:0]   wait_cnt, wait_cnt_n;
    logic              origin_step, origin_step_n;
    logic              halt_pend, halt_pend_n;
    logic              timeout_n;
    logic              step_q;
    logic              step_pulse;
    logic              stall;
    logic              boundary;
    logic              halt_now;
    logic              in_cycle;

    assign State      = state;
    assign step_pulse = Step & ~step_q;
    assign stall      = (Phase == 2'd1) & Mem_req & ~Mem_ready;
    assign Advance    = ((state == RUN) | (state == STEP)) & ~stall;
    assign boundary   = Advance & (Phase == 2'd2);
    // A halt request seen mid-cycle (including during WAIT) is held until the boundary.
    assign halt_now   = Halt_req | halt_pend;
    assign in_cycle   = (state == RUN) | (state == STEP) | (state == WAIT);

    always_comb begin
        state_n       = state;
        wait_cnt_n    = wait_cnt;
        origin_step_n = origin_step;
        timeout_n     = Timeout;
        phase_n       = Phase;

        if (Phase == 2'd3) begin
            phase_n = 2'd0;
        end else if (Advance) begin
            phase_n = (Phase == 2'd2) ? 2'd0 : Phase + 2'd1;
        end

        case (state)
            IDLE: begin
                if (Halt_req) begin
                    state_n = HALTED;
                end else if (Run) begin
                    state_n = RUN;
                end else if (step_pulse) begin
                    state_n = STEP;
                end
            end
            RUN: begin
                if (stall) begin
                    state_n       = WAIT;
                    wait_cnt_n    = '0;
                    origin_step_n = 1'b0;
                end else if (boundary) begin
                    if (halt_now) begin
                        state_n = HALTED;
                    end else if (!Run) begin
                        state_n = IDLE;
                    end
                end
            end
            STEP: begin
                if (stall) begin
                    state_n       = WAIT;
                    wait_cnt_n    = '0;
                    origin_step_n = 1'b1;
                end else if (boundary) begin
                    state_n = halt_now ? HALTED : IDLE;
                end
            end
            WAIT: begin
                if (Mem_ready) begin
                    state_n = origin_step ? STEP : RUN;
                end else if (wait_cnt == WC_W'(WAIT_MAX - 1)) begin
                    state_n   = HALTED;
                    timeout_n = 1'b1;
                end else begin
                    wait_cnt_n = wait_cnt + WC_W'(1);
                end
            end
            HALTED: begin
                if (Clear) begin
                    state_n   = IDLE;
                    timeout_n = 1'b0;
                    phase_n   = 2'd0;
                end
            end
            default: begin
                state_n = IDLE;
            end
        endcase

        halt_pend_n = in_cycle & halt_now & (state_n != IDLE) & (state_n != HALTED);
    end

    always_ff @(posedge Cin or negedge Reset) begin
        if (!Reset) begin
            state       <= IDLE;
            Phase       <= 2'd0;
            Cycle_count <= '0;
            Cycle_done  <= 1'b0;
            Timeout     <= 1'b0;
            wait_cnt    <= '0;
            origin_step <= 1'b0;
            halt_pend   <= 1'b0;
            step_q      <= 1'b0;
        end else begin
            state       <= state_n;
            Phase       <= phase_n;
            Timeout     <= timeout_n;
            wait_cnt    <= wait_cnt_n;
            origin_step <= origin_step_n;
            halt_pend   <= halt_pend_n;
            step_q      <= Step;
            Cycle_done  <= boundary;
            if (boundary) begin
                Cycle_count <= Cycle_count + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_phase_sequencer.sv
// Scoreboarded bench for phase_sequencer: directed scenarios plus random control
// traffic, checked each cycle against a behavioural model of the sequencing rules.
module tb_phase_sequencer;

    localparam int WAIT_MAX = 7;
    localparam int CNT_W    = 16;

    logic             Cin = 1'b0;
    logic             Reset = 1'b0;
    logic             Run = 1'b0, Step = 1'b0, Halt_req = 1'b0, Clear = 1'b0;
    logic             Mem_req = 1'b0, Mem_ready = 1'b0;
    logic             Advance;
    logic [1:0]       Phase;
    logic [2:0]       State;
    logic             Cycle_done;
    logic             Timeout;
    logic [CNT_W-1:0] Cycle_count;

    phase_sequencer #(.WAIT_MAX(WAIT_MAX), .CNT_W(CNT_W)) dut (
        .Cin(Cin), .Reset(Reset), .Run(Run), .Step(Step), .Halt_req(Halt_req),
        .Clear(Clear), .Mem_req(Mem_req), .Mem_ready(Mem_ready),
        .Advance(Advance), .Phase(Phase), .State(State), .Cycle_done(Cycle_done),
        .Timeout(Timeout), .Cycle_count(Cycle_count)
    );

    always #5 Cin = ~Cin;

    typedef struct {
        bit adv;
        int ph;
        int st;
        bit done;
        bit to;
        int cnt;
    } exp_t;

    exp_t exp_q[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    // Behavioural model: mode 0 idle, 1 running, 2 stepping, 3 waiting, 4 halted.
    int m_mode, m_ph, m_waited, m_cycles;
    bit m_back_to_step, m_halt_wanted, m_to, m_done, m_step_prev;
    bit p_run, p_step, p_halt, p_clr, p_mreq, p_mrdy;

    task automatic model_reset();
        m_mode = 0; m_ph = 0; m_waited = 0; m_cycles = 0;
        m_back_to_step = 0; m_halt_wanted = 0; m_to = 0; m_done = 0; m_step_prev = 0;
    endtask

    function automatic bit model_adv(bit mreq, bit mrdy);
        bit held = (m_ph == 1) && mreq && !mrdy;
        return (m_mode == 1 || m_mode == 2) && !held;
    endfunction

    task automatic model_step(bit run, bit step, bit halt, bit clr, bit mreq, bit mrdy);
        bit held  = (m_ph == 1) && mreq && !mrdy;
        bit adv   = model_adv(mreq, mrdy);
        bit ends  = adv && (m_ph == 2);
        bit want  = halt || m_halt_wanted;
        int nmode = m_mode;
        if (m_mode == 0) begin
            if (halt) nmode = 4;
            else if (run) nmode = 1;
            else if (step && !m_step_prev) nmode = 2;
        end else if (m_mode == 1 || m_mode == 2) begin
            if (held) begin
                nmode = 3; m_waited = 0; m_back_to_step = (m_mode == 2);
            end else if (ends) begin
                if (want) nmode = 4;
                else if (m_mode == 2 || !run) nmode = 0;
            end
        end else if (m_mode == 3) begin
            if (mrdy) nmode = m_back_to_step ? 2 : 1;
            else if (m_waited + 1 >= WAIT_MAX) begin nmode = 4; m_to = 1; end
            else m_waited++;
        end else if (m_mode == 4 && clr) begin
            nmode = 0; m_to = 0; m_ph = 0;
        end
        m_halt_wanted = (m_mode >= 1 && m_mode <= 3) && want && nmode != 0 && nmode != 4;
        if (adv) m_ph = (m_ph + 1) % 3;
        if (ends) m_cycles = (m_cycles + 1) % (1 << CNT_W);
        m_done      = ends;
        m_step_prev = step;
        m_mode      = nmode;
    endtask

    task automatic chk(string nm, logic [31:0] act, logic [31:0] expv);
        n_cmp++;
        if (act !== expv) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, expv, $time);
        end
    endtask

    // One clock of stimulus: advance the model over the edge just taken, then apply new inputs.
    task automatic drive_cycle(bit rst_n, bit run, bit step, bit halt, bit clr, bit mreq, bit mrdy);
        exp_t e;
        @(posedge Cin);
        #1;
        if (!Reset) model_reset();
        else model_step(p_run, p_step, p_halt, p_clr, p_mreq, p_mrdy);
        Reset = rst_n; Run = run; Step = step; Halt_req = halt; Clear = clr;
        Mem_req = mreq; Mem_ready = mrdy;
        p_run = run; p_step = step; p_halt = halt; p_clr = clr; p_mreq = mreq; p_mrdy = mrdy;
        if (!rst_n) model_reset();
        e.adv = model_adv(mreq, mrdy);
        e.ph = m_ph; e.st = m_mode; e.done = m_done; e.to = m_to; e.cnt = m_cycles;
        exp_q.push_back(e);
    endtask

    always @(negedge Cin) begin
        if (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            chk("Advance", 32'(Advance), 32'(e.adv));
            chk("Phase", 32'(Phase), 32'(e.ph));
            chk("State", 32'(State), 32'(e.st));
            chk("Cycle_done", 32'(Cycle_done), 32'(e.done));
            chk("Timeout", 32'(Timeout), 32'(e.to));
            chk("Cycle_count", 32'(Cycle_count), 32'(e.cnt));
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got no finish expected finish before time limit");
        $fatal(1);
    end

    initial begin
        model_reset();
        {p_run, p_step, p_halt, p_clr, p_mreq, p_mrdy} = '0;

        repeat (2) drive_cycle(0, 0, 0, 0, 0, 0, 0);

        // Free run, then drop Run mid-cycle.
        repeat (10) drive_cycle(1, 1, 0, 0, 0, 0, 0);
        repeat (6)  drive_cycle(1, 0, 0, 0, 0, 0, 0);

        // Step held high, then a second edge.
        repeat (2) begin
            repeat (10) drive_cycle(1, 0, 1, 0, 0, 0, 0);
            repeat (2)  drive_cycle(1, 0, 0, 0, 0, 0, 0);
        end

        // Wait states that resolve before timeout.
        for (int i = 0; i < 30; i++) drive_cycle(1, 1, 0, 0, 0, 1, (i % 5) == 4);

        // Wait-state timeout, Run ignored while halted, then Clear.
        repeat (15) drive_cycle(1, 1, 0, 0, 0, 1, 0);
        drive_cycle(1, 1, 1, 1, 0, 0, 0);
        drive_cycle(1, 1, 0, 0, 1, 0, 0);
        repeat (3) drive_cycle(1, 0, 0, 0, 0, 0, 0);

        // One-cycle halt pulse in mid-cycle, then Clear.
        repeat (4) drive_cycle(1, 1, 0, 0, 0, 0, 0);
        drive_cycle(1, 1, 0, 1, 0, 0, 0);
        repeat (6) drive_cycle(1, 1, 0, 0, 0, 0, 0);
        drive_cycle(1, 0, 0, 0, 1, 0, 0);

        // Halt requested during WAIT must still be honoured at the boundary.
        repeat (3) drive_cycle(1, 1, 0, 0, 0, 0, 0);
        drive_cycle(1, 1, 0, 0, 0, 1, 0);
        drive_cycle(1, 1, 0, 1, 0, 1, 0);
        drive_cycle(1, 1, 0, 0, 0, 1, 1);
        repeat (5) drive_cycle(1, 1, 0, 0, 0, 0, 0);
        drive_cycle(1, 0, 0, 0, 1, 0, 0);

        // Reach WAIT with five completed cycles, then reset asynchronously.
        drive_cycle(0, 0, 0, 0, 0, 0, 0);
        repeat (16) drive_cycle(1, 1, 0, 0, 0, 0, 0);
        repeat (3)  drive_cycle(1, 1, 0, 0, 0, 1, 0);
        @(negedge Cin);
        #2;
        chk("pre_reset_state", 32'(State), 32'd3);
        chk("pre_reset_count", 32'(Cycle_count), 32'd5);
        Reset = 1'b0;
        #1;
        chk("async_state", 32'(State), 32'd0);
        chk("async_phase", 32'(Phase), 32'd0);
        chk("async_count", 32'(Cycle_count), 32'd0);
        chk("async_timeout", 32'(Timeout), 32'd0);
        chk("async_advance", 32'(Advance), 32'd0);
        chk("async_done", 32'(Cycle_done), 32'd0);
        model_reset();
        repeat (8) drive_cycle(1, 1, 0, 0, 0, 0, 0);

        // Random control traffic.
        for (int i = 0; i < 2000; i++) begin
            drive_cycle(($urandom_range(0, 199) != 0),
                        ($urandom_range(0, 9) < 6),
                        ($urandom_range(0, 9) < 3),
                        ($urandom_range(0, 29) == 0),
                        ($urandom_range(0, 9) < 2),
                        ($urandom_range(0, 1) == 1),
                        ($urandom_range(0, 9) < 5));
        end
        drive_cycle(1, 0, 0, 0, 0, 0, 0);

        repeat (3) @(negedge Cin);
        #1;
        if (exp_q.size() != 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL drain: got %0d pending expected 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
